// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control path.
// Opcodes, ALUOp codes and the main control state enum.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDIEX  = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Moore main control FSM for the multicycle MIPS datapath.
// Outputs decode from the state register; reset forces them all low.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                if (Op == OP_LW || Op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (Op == OP_RTYPE) begin
                    state_d = S_EXECUTE;
                end else if (Op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (Op == OP_ADDI) begin
                    state_d = S_ADDIEX;
                end else if (Op == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    state_d = S_FETCH;
                end
            end
            // IR holds Op stable, so re-reading it here picks lw vs sw
            S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALUOP_ADD;
        PCSource    = PCSRC_ALU;
        Illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMMSH;
                    Illegal = !op_legal(Op);
                end
                S_MEMADR, S_ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                S_EXECUTE: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                S_ADDIWB: begin
                    RegWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALUOP_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PCSRC_JUMP;
                end
                default: begin
                    PCWrite = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench: per-instruction cycle model pushes expected outputs,
// a negedge monitor pops and compares every cycle.
module tb_mips_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] Op;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, Illegal;
    logic [1:0] ALUSrcB, ALUOp, PCSource;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .Op(Op),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .Illegal(Illegal)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef logic [16:0] vec_t;
    typedef struct {
        vec_t       v;
        logic [5:0] op;
        int         step;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // field order: pcw pcwc iord mr mw irw m2r rdst rw asa asb aop pcs ill
    function automatic vec_t mk(input logic pcw, pcwc, iord, mr, mw, irw,
                                input logic m2r, rdst, rw, asa,
                                input logic [1:0] asb, aop, pcs,
                                input logic ill);
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
                asb, aop, pcs, ill};
    endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
    endfunction

    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'h23:               return 5;
            6'h2b, 6'h00, 6'h08: return 4;
            6'h04, 6'h02:        return 3;
            default:             return 2;
        endcase
    endfunction

    // Expected control word at cycle 'step' of instruction 'op'
    function automatic vec_t exp_vec(input logic [5:0] op, input int step);
        vec_t addr = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        if (step == 0)
            return mk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        if (step == 1)
            return mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!legal(op));
        case (op)
            6'h23: begin
                if (step == 2) return addr;
                if (step == 3)
                    return mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
                return mk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
            end
            6'h2b: begin
                if (step == 2) return addr;
                return mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
            end
            6'h00: begin
                if (step == 2)
                    return mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
                return mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
            end
            6'h08: begin
                if (step == 2) return addr;
                return mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
            end
            6'h04: return mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
            6'h02: return mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
            default: return '0;
        endcase
    endfunction

    task automatic push(input vec_t v, input logic [5:0] op, input int s);
        exp_t e;
        e.v = v;
        e.op = op;
        e.step = s;
        exp_q.push_back(e);
    endtask

    // abort_at < 0: run to completion; else raise reset in that cycle
    task automatic run_instr(input logic [5:0] op, input int abort_at);
        int n = instr_len(op);
        for (int s = 0; s < n; s++) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
            if (s == 0) Op = op;
            if (s == abort_at) begin
                reset = 1'b1;
                push('0, op, -1);
                return;
            end
            push(exp_vec(op, s), op, s);
        end
    endtask

    initial begin : monitor
        vec_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
                       ALUSrcB, ALUOp, PCSource, Illegal};
                tests++;
                if (act !== e.v) begin
                    fails++;
                    $display("FAIL ctrl op=%b step=%0d t=%0t got=%b want=%b",
                             e.op, e.step, $time, act, e.v);
                end
            end
        end
    end

    logic [5:0] legal_ops [6];

    initial begin : driver
        logic [5:0] op;
        int         ab;
        legal_ops[0] = 6'h00;
        legal_ops[1] = 6'h23;
        legal_ops[2] = 6'h2b;
        legal_ops[3] = 6'h04;
        legal_ops[4] = 6'h08;
        legal_ops[5] = 6'h02;
        reset = 1'b1;
        Op = 6'h00;
        push('0, 6'h00, -1);
        @(posedge clk);
        #1;
        push('0, 6'h00, -1);

        run_instr(6'b100011, -1);
        run_instr(6'b000000, -1);
        run_instr(6'b000100, -1);
        run_instr(6'b000010, -1);
        run_instr(6'b101011, -1);
        run_instr(6'b001000, -1);
        run_instr(6'b111111, -1);
        run_instr(6'b100011, 3);
        run_instr(6'b100011, -1);
        run_instr(6'b000000, 3);
        run_instr(6'b000100, 0);
        run_instr(6'b101011, -1);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 0)
                op = legal_ops[$urandom_range(0, 5)];
            else
                op = 6'($urandom);
            ab = -1;
            if ($urandom_range(0, 9) == 0)
                ab = $urandom_range(0, instr_len(op) - 1);
            run_instr(op, ab);
        end

        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
